alu_cmd_issue: RTL and testbench

// - Upstream issue stage for the 4-bit combinational ALU (A, B, ALU_Sel -> ALU_Out).
// - Buffers operation commands in a small FIFO and presents one command at a time on the ALU inputs.
// - Registers the ALU result with zero and illegal-op flags, and hands it downstream on a valid/ready port.
// - Sits between the command source (decoder or testbench driver) and the result consumer; the ALU instance is external, at the same level.
//

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_cmd_fifo.sv | 66 ++++++
 rtl/alu_cmd_issue.sv | 129 ++++++++++++
 tb/tb_alu_cmd_issue.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU widths, opcodes, command record and issue-stage state encoding.
// Rev 1.0
`default_nettype none

package alu_pkg;

  localparam int ALU_DATA_W = 4;
  localparam int ALU_SEL_W  = 3;
  localparam int ALU_TAG_W  = 2;

  localparam logic [ALU_SEL_W-1:0] ALU_SEL_ADD = 3'd0;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_SUB = 3'd1;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_AND = 3'd2;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_OR  = 3'd3;
  localparam logic [ALU_SEL_W-1:0] ALU_SEL_NOT = 3'd4;

  typedef struct packed {
    logic [ALU_SEL_W-1:0]  sel;
    logic [ALU_DATA_W-1:0] a;
    logic [ALU_DATA_W-1:0] b;
    logic [ALU_TAG_W-1:0]  tag;
  } alu_cmd_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    HOLD = 2'd2
  } issue_state_t;

endpackage

`default_nettype wire

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: DEPTH-entry synchronous FIFO of ALU commands with occupancy count.
// Rev 1.0
`default_nettype none

module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  alu_cmd_t         din_i,
  output alu_cmd_t         dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  alu_cmd_t         mem_q [DEPTH];
  logic             push_w, pop_w;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];

  assign push_w = push_i && !full_o;
  assign pop_w  = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    if (push_w && !pop_w) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push_w && pop_w) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // Pointers are exactly log2(DEPTH) wide, so the increment wraps modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_w) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_w)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_w) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/alu_cmd_issue.sv
// alu_cmd_issue: queues ALU commands, issues one per EXEC cycle, registers the result
// with zero/illegal flags and hands it off on a valid/ready port. Rev 1.0
`default_nettype none

module alu_cmd_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = ALU_TAG_W
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [ALU_SEL_W-1:0]    cmd_sel,
  input  logic [ALU_DATA_W-1:0]   cmd_a,
  input  logic [ALU_DATA_W-1:0]   cmd_b,
  input  logic [TAG_W-1:0]        cmd_tag,
  output logic [ALU_DATA_W-1:0]   alu_a,
  output logic [ALU_DATA_W-1:0]   alu_b,
  output logic [ALU_SEL_W-1:0]    alu_sel,
  input  logic [ALU_DATA_W-1:0]   alu_out,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [ALU_DATA_W-1:0]   res_data,
  output logic                    res_zero,
  output logic                    res_illegal,
  output logic [TAG_W-1:0]        res_tag,
  output logic [$clog2(DEPTH):0]  fifo_count,
  output logic [7:0]              op_count
);

  issue_state_t          state_q, state_d;
  logic                  res_valid_q, res_valid_d;
  logic [ALU_DATA_W-1:0] res_data_q, res_data_d;
  logic                  res_zero_q, res_zero_d;
  logic                  res_illegal_q, res_illegal_d;
  logic [TAG_W-1:0]      res_tag_q, res_tag_d;
  logic [7:0]            op_count_q, op_count_d;

  alu_cmd_t fifo_din, fifo_head;
  logic     fifo_full, fifo_empty, push, pop;

  assign fifo_din = '{sel: cmd_sel, a: cmd_a, b: cmd_b, tag: ALU_TAG_W'(cmd_tag)};
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && !fifo_full;

  alu_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   (fifo_din),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    res_valid_d   = res_valid_q;
    res_data_d    = res_data_q;
    res_zero_d    = res_zero_q;
    res_illegal_d = res_illegal_q;
    res_tag_d     = res_tag_q;
    op_count_d    = op_count_q;
    alu_a         = '0;
    alu_b         = '0;
    alu_sel       = '0;
    pop           = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) state_d = EXEC;
      end
      EXEC: begin
        alu_a         = fifo_head.a;
        alu_b         = fifo_head.b;
        alu_sel       = fifo_head.sel;
        pop           = 1'b1;
        res_data_d    = alu_out;
        res_zero_d    = (alu_out == '0);
        res_illegal_d = (fifo_head.sel > ALU_SEL_NOT);
        res_tag_d     = TAG_W'(fifo_head.tag);
        res_valid_d   = 1'b1;
        state_d       = HOLD;
      end
      HOLD: begin
        // A command accepted in the hand-off cycle is enough to go straight to EXEC.
        if (res_ready) begin
          op_count_d  = op_count_q + 8'd1;
          res_valid_d = 1'b0;
          state_d     = (!fifo_empty || push) ? EXEC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      res_valid_q   <= 1'b0;
      res_data_q    <= '0;
      res_zero_q    <= 1'b0;
      res_illegal_q <= 1'b0;
      res_tag_q     <= '0;
      op_count_q    <= '0;
    end else begin
      state_q       <= state_d;
      res_valid_q   <= res_valid_d;
      res_data_q    <= res_data_d;
      res_zero_q    <= res_zero_d;
      res_illegal_q <= res_illegal_d;
      res_tag_q     <= res_tag_d;
      op_count_q    <= op_count_d;
    end
  end

  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_zero    = res_zero_q;
  assign res_illegal = res_illegal_q;
  assign res_tag     = res_tag_q;
  assign op_count    = op_count_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_cmd_issue.sv
// tb_alu_cmd_issue: ALU issue stage wired to a behavioural ALU, checked against a
// result scoreboard and occupancy bookkeeping, plus directed literal expectations.
`default_nettype none

module tb_alu_cmd_issue;
  import alu_pkg::*;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready;
  logic [2:0] cmd_sel = '0;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic [1:0] cmd_tag = '0;
  logic [3:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_sel;
  logic       res_valid, res_ready = 1'b0;
  logic [3:0] res_data;
  logic       res_zero, res_illegal;
  logic [1:0] res_tag;
  logic [2:0] fifo_count;
  logic [7:0] op_count;

  always #5 clk = ~clk;

  function automatic logic [3:0] alu_f(logic [2:0] s, logic [3:0] a, logic [3:0] b);
    case (s)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return ~a;
      default: return 4'd0;
    endcase
  endfunction

  assign alu_out = alu_f(alu_sel, alu_a, alu_b);

  alu_cmd_issue #(.DEPTH(DEPTH), .TAG_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_sel(cmd_sel), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_tag(cmd_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_zero(res_zero), .res_illegal(res_illegal), .res_tag(res_tag),
    .fifo_count(fifo_count), .op_count(op_count)
  );

  int n_vec = 0, n_err = 0;

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Result record: {tag, illegal, zero, data}
  function automatic logic [7:0] expect_of(logic [2:0] s, logic [3:0] a, logic [3:0] b, logic [1:0] t);
    logic [3:0] d;
    d = alu_f(s, a, b);
    return {t, (s > 3'd4), (d == 4'd0), d};
  endfunction

  logic [7:0] exp_q[$];
  logic [7:0] obs_q[$];
  logic [7:0] cmp_e;
  int         acc = 0, handed = 0, ops = 0;
  logic       rr_rand = 1'b0;

  // Every queued-but-not-handed command sits in the FIFO unless it is the held result.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      obs_q.delete();
      acc = 0; handed = 0; ops = 0;
    end else begin
      chk("op_count", int'(op_count), ops % 256);
      chk("fifo_count", int'(fifo_count), acc - handed - (res_valid ? 1 : 0));
      chk("cmd_ready", int'(cmd_ready), (fifo_count != 3'(DEPTH)) ? 1 : 0);
      if (res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          cmp_e = exp_q.pop_front();
          chk("result", int'({res_tag, res_illegal, res_zero, res_data}), int'(cmp_e));
        end
        obs_q.push_back({res_tag, res_illegal, res_zero, res_data});
        handed++;
        ops++;
      end
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back(expect_of(cmd_sel, cmd_a, cmd_b, cmd_tag));
        acc++;
      end
    end
  end

  always @(posedge clk) begin
    if (rr_rand) begin
      #1 res_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cmd_valid = 1'b0;
    res_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  task automatic push(input logic [2:0] s, input logic [3:0] a, input logic [3:0] b, input logic [1:0] t);
    cmd_sel = s; cmd_a = a; cmd_b = b; cmd_tag = t;
    cmd_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        tick();
        cmd_valid = 1'b0;
        return;
      end
    end
    chk("push_timeout", 0, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 400; i++) begin
      if (exp_q.size() == 0 && !res_valid && fifo_count == 3'd0) return;
      tick();
    end
    chk("drain_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state while held in reset
    rst_n = 1'b0;
    repeat (2) tick();
    chk("rst_res_valid", int'(res_valid), 0);
    chk("rst_cmd_ready", int'(cmd_ready), 1);
    chk("rst_fifo_count", int'(fifo_count), 0);
    chk("rst_alu", int'({alu_a, alu_b, alu_sel}), 0);
    chk("rst_op_count", int'(op_count), 0);
    rst_n = 1'b1;

    // Single op: latency and literal result
    res_ready = 1'b1;
    push(3'd0, 4'd9, 4'd8, 2'd2);
    chk("t2_count_after_accept", int'(fifo_count), 1);
    chk("t2_valid_t0", int'(res_valid), 0);
    tick();
    chk("t2_exec_a", int'(alu_a), 9);
    chk("t2_exec_b", int'(alu_b), 8);
    chk("t2_exec_sel", int'(alu_sel), 0);
    chk("t2_valid_t1", int'(res_valid), 0);
    tick();
    chk("t2_valid_t2", int'(res_valid), 1);
    chk("t2_data", int'(res_data), 1);
    chk("t2_zero", int'(res_zero), 0);
    chk("t2_illegal", int'(res_illegal), 0);
    chk("t2_tag", int'(res_tag), 2);
    chk("t2_hold_alu", int'({alu_a, alu_b, alu_sel}), 0);
    tick();
    chk("t2_valid_after", int'(res_valid), 0);
    chk("t2_op_count", int'(op_count), 1);

    // Back-to-back ops
    do_reset();
    res_ready = 1'b1;
    push(3'd1, 4'd3, 4'd3, 2'd0);
    push(3'd2, 4'hC, 4'h3, 2'd1);
    push(3'd4, 4'hF, 4'h0, 2'd2);
    push(3'd3, 4'h5, 4'hA, 2'd3);
    wait_drain();
    chk("t3_n_results", obs_q.size(), 4);
    if (obs_q.size() == 4) begin
      chk("t3_r0", int'(obs_q[0][5:0]), 6'h10);
      chk("t3_r1", int'(obs_q[1][5:0]), 6'h10);
      chk("t3_r2", int'(obs_q[2][5:0]), 6'h10);
      chk("t3_r3", int'(obs_q[3]), 8'hCF);
    end
    chk("t3_op_count", int'(op_count), 4);

    // Backpressure: one held, four fill the FIFO
    do_reset();
    push(3'd0, 4'd1, 4'd2, 2'd0);
    push(3'd0, 4'd3, 4'd4, 2'd1);
    push(3'd0, 4'd5, 4'd6, 2'd2);
    push(3'd0, 4'd7, 4'd8, 2'd3);
    push(3'd0, 4'd9, 4'd9, 2'd0);
    tick();
    chk("t4_full_ready", int'(cmd_ready), 0);
    chk("t4_full_count", int'(fifo_count), 4);
    chk("t4_held_valid", int'(res_valid), 1);
    chk("t4_held_data", int'(res_data), 3);
    res_ready = 1'b1;
    wait_drain();
    chk("t4_n_results", obs_q.size(), 5);
    if (obs_q.size() == 5) begin
      chk("t4_d0", int'(obs_q[0][3:0]), 3);
      chk("t4_d1", int'(obs_q[1][3:0]), 7);
      chk("t4_d2", int'(obs_q[2][3:0]), 11);
      chk("t4_d3", int'(obs_q[3][3:0]), 15);
      chk("t4_d4", int'(obs_q[4][3:0]), 2);
    end

    // Illegal op followed by legal op
    do_reset();
    res_ready = 1'b1;
    push(3'd6, 4'd7, 4'd2, 2'd1);
    push(3'd0, 4'd1, 4'd1, 2'd2);
    wait_drain();
    chk("t5_n_results", obs_q.size(), 2);
    if (obs_q.size() == 2) begin
      chk("t5_illegal_rec", int'(obs_q[0]), 8'h70);
      chk("t5_legal_rec", int'(obs_q[1]), 8'h82);
    end

    // Reset mid-HOLD with 3 commands queued
    do_reset();
    push(3'd0, 4'd1, 4'd1, 2'd0);
    push(3'd1, 4'd5, 4'd1, 2'd1);
    push(3'd2, 4'd6, 4'd3, 2'd2);
    push(3'd3, 4'd8, 4'd1, 2'd3);
    chk("t1_pre_valid", int'(res_valid), 1);
    chk("t1_pre_count", int'(fifo_count), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("t1_res_valid", int'(res_valid), 0);
    chk("t1_fifo_count", int'(fifo_count), 0);
    chk("t1_cmd_ready", int'(cmd_ready), 1);
    chk("t1_alu", int'({alu_a, alu_b, alu_sel}), 0);
    chk("t1_op_count", int'(op_count), 0);
    repeat (2) tick();
    rst_n = 1'b1;

    // Random mixed ops with random backpressure
    rr_rand = 1'b1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      push(3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom), 2'($urandom));
    end
    rr_rand = 1'b0;
    #1 res_ready = 1'b1;
    wait_drain();

    // Wrap: 260 ADD ops
    do_reset();
    rr_rand = 1'b1;
    for (int i = 0; i < 260; i++) begin
      repeat ($urandom_range(0, 1)) tick();
      push(3'd0, 4'($urandom), 4'($urandom), 2'($urandom));
    end
    rr_rand = 1'b0;
    #1 res_ready = 1'b1;
    wait_drain();
    chk("t6_op_count_wrap", int'(op_count), 4);
    chk("t6_n_results", obs_q.size(), 260);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
